// File: rtl/payload_parser_pkg.sv
// Shared layout constants and state encoding for the fixed 39-byte order payload.
package payload_pkg;

   localparam int unsigned MSG_LEN     = 39;
   localparam int unsigned OFF_EXEC    = 0;
   localparam int unsigned OFF_UD      = 1;
   localparam int unsigned OFF_SYMTYPE = 9;
   localparam int unsigned OFF_SYM     = 10;
   localparam int unsigned OFF_PRICE   = 30;
   localparam int unsigned OFF_QTY     = 34;
   localparam int unsigned OFF_SIDE    = 36;
   localparam int unsigned OFF_ORD     = 37;
   localparam int unsigned OFF_TIF     = 38;

   localparam int unsigned SYM_BYTES   = 20;
   localparam int unsigned PRICE_BYTES = 4;
   localparam int unsigned QTY_BYTES   = 2;
   localparam int unsigned SYM_W       = 8 * SYM_BYTES;
   localparam int unsigned PRICE_W     = 8 * PRICE_BYTES;
   localparam int unsigned QTY_W       = 8 * QTY_BYTES;

   localparam logic [5:0] LAST_IDX = 6'(MSG_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_DROP
   } state_e;

endpackage

// File: rtl/payload_parser_if.sv
// Byte-stream input bus of the payload parser.
interface payload_parser_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_sop;
   logic       s_eop;
   logic       s_ready;

   modport master (output s_valid, s_data, s_sop, s_eop, input s_ready);
   modport slave  (input s_valid, s_data, s_sop, s_eop, output s_ready);
endinterface

// File: rtl/payload_parser.sv
// Decodes a fixed 39-byte message into registered fields; flags short, long and aborted messages.
module payload_parser
   import payload_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   payload_parser_if.slave     s,
   output logic                fields_valid,
   output logic                len_err,
   output logic [7:0]          ExecType_o,
   output logic [7:0]          user_define0_o,
   output logic [7:0]          user_define1_o,
   output logic [7:0]          user_define2_o,
   output logic [7:0]          user_define3_o,
   output logic [7:0]          user_define4_o,
   output logic [7:0]          user_define5_o,
   output logic [7:0]          user_define6_o,
   output logic [7:0]          user_define7_o,
   output logic [7:0]          symbol_type_o,
   output logic [SYM_W-1:0]    sym_o,
   output logic [PRICE_W-1:0]  price_o,
   output logic [QTY_W-1:0]    qty_o,
   output logic [7:0]          side_o,
   output logic [7:0]          OrdType_o,
   output logic [7:0]          TimeInForce_o
);

   state_e     state_q;
   logic [5:0] idx_q;
   logic [7:0] msg_q [MSG_LEN];
   logic       fields_valid_q;
   logic       len_err_q;

   logic       wr_en_d;
   logic [5:0] wr_idx_d;

   assign s.s_ready    = 1'b1;
   assign fields_valid = fields_valid_q;
   assign len_err      = len_err_q;

   // A start-of-packet byte always lands at offset 0, whatever state we are in.
   always_comb begin
      wr_en_d  = 1'b0;
      wr_idx_d = '0;
      if (s.s_valid) begin
         if (state_q == ST_RECV) begin
            wr_en_d  = 1'b1;
            wr_idx_d = s.s_sop ? '0 : idx_q;
         end else begin
            wr_en_d  = s.s_sop;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         fields_valid_q <= 1'b0;
         len_err_q      <= 1'b0;
         for (int unsigned i = 0; i < MSG_LEN; i++) msg_q[i] <= '0;
      end else begin
         fields_valid_q <= 1'b0;
         len_err_q      <= 1'b0;
         if (wr_en_d) msg_q[wr_idx_d] <= s.s_data;
         if (s.s_valid) begin
            unique case (state_q)
               ST_IDLE, ST_DROP: begin
                  if (s.s_sop) begin
                     if (s.s_eop) begin
                        len_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                        idx_q     <= '0;
                     end else begin
                        state_q   <= ST_RECV;
                        idx_q     <= 6'd1;
                     end
                  end else if (state_q == ST_DROP && s.s_eop) begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_RECV: begin
                  if (s.s_sop) begin
                     // Abort the message in flight; this byte restarts at offset 0.
                     len_err_q <= 1'b1;
                     if (s.s_eop) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                     end else begin
                        idx_q   <= 6'd1;
                     end
                  end else if (s.s_eop) begin
                     state_q <= ST_IDLE;
                     idx_q   <= '0;
                     if (idx_q == LAST_IDX) fields_valid_q <= 1'b1;
                     else                   len_err_q      <= 1'b1;
                  end else if (idx_q == LAST_IDX) begin
                     len_err_q <= 1'b1;
                     state_q   <= ST_DROP;
                     idx_q     <= '0;
                  end else begin
                     idx_q <= idx_q + 6'd1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  idx_q   <= '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      ExecType_o     = msg_q[OFF_EXEC];
      user_define0_o = msg_q[OFF_UD + 0];
      user_define1_o = msg_q[OFF_UD + 1];
      user_define2_o = msg_q[OFF_UD + 2];
      user_define3_o = msg_q[OFF_UD + 3];
      user_define4_o = msg_q[OFF_UD + 4];
      user_define5_o = msg_q[OFF_UD + 5];
      user_define6_o = msg_q[OFF_UD + 6];
      user_define7_o = msg_q[OFF_UD + 7];
      symbol_type_o  = msg_q[OFF_SYMTYPE];
      side_o         = msg_q[OFF_SIDE];
      OrdType_o      = msg_q[OFF_ORD];
      TimeInForce_o  = msg_q[OFF_TIF];
      sym_o          = '0;
      price_o        = '0;
      qty_o          = '0;
      // Big-endian: lowest offset fills the most significant byte.
      for (int unsigned k = 0; k < SYM_BYTES; k++)
         sym_o[SYM_W - 1 - 8 * k -: 8] = msg_q[OFF_SYM + k];
      for (int unsigned k = 0; k < PRICE_BYTES; k++)
         price_o[PRICE_W - 1 - 8 * k -: 8] = msg_q[OFF_PRICE + k];
      for (int unsigned k = 0; k < QTY_BYTES; k++)
         qty_o[QTY_W - 1 - 8 * k -: 8] = msg_q[OFF_QTY + k];
   end

endmodule

// File: tb/tb_payload_parser.sv
// Directed bench for payload_parser: valid, gapped, short, long, aborted, reset-interrupted messages.
module tb_payload_parser;
   import payload_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   payload_parser_if bus ();

   logic         fields_valid, len_err;
   logic [7:0]   ExecType_o, symbol_type_o, side_o, OrdType_o, TimeInForce_o;
   logic [7:0]   ud0, ud1, ud2, ud3, ud4, ud5, ud6, ud7;
   logic [159:0] sym_o;
   logic [31:0]  price_o;
   logic [15:0]  qty_o;

   payload_parser dut (
      .clk            (clk),
      .resetn         (resetn),
      .s              (bus),
      .fields_valid   (fields_valid),
      .len_err        (len_err),
      .ExecType_o     (ExecType_o),
      .user_define0_o (ud0),
      .user_define1_o (ud1),
      .user_define2_o (ud2),
      .user_define3_o (ud3),
      .user_define4_o (ud4),
      .user_define5_o (ud5),
      .user_define6_o (ud6),
      .user_define7_o (ud7),
      .symbol_type_o  (symbol_type_o),
      .sym_o          (sym_o),
      .price_o        (price_o),
      .qty_o          (qty_o),
      .side_o         (side_o),
      .OrdType_o      (OrdType_o),
      .TimeInForce_o  (TimeInForce_o)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       sop;
      logic       eop;
   } beat_t;

   beat_t      q[$];
   logic [7:0] msgA [39];
   logic [7:0] msgB [39];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         fv_n, le_n, fv_at, le_at;

   localparam logic [159:0] SYM_AAPL = 160'h4141504C_20202020_20202020_20202020_20202020;

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic sop, input logic eop);
      bus.s_valid = v;
      bus.s_data  = d;
      bus.s_sop   = sop;
      bus.s_eop   = eop;
   endtask

   task automatic sample(input int k);
      check("excl", {159'd0, fields_valid & len_err}, 160'd0);
      if (fields_valid === 1'b1) begin fv_n++; fv_at = k; end
      if (len_err === 1'b1)      begin le_n++; le_at = k; end
   endtask

   task automatic add_msg(input bit use_b, input int last, input bit eop_last);
      for (int i = 0; i <= last; i++)
         q.push_back('{use_b ? msgB[i] : msgA[i], i == 0, eop_last && (i == last)});
   endtask

   // Gap cycles carry junk data and flags to show s_valid alone qualifies a byte.
   task automatic send(input bit gap);
      fv_n = 0; le_n = 0; fv_at = -1; le_at = -1;
      for (int k = 0; k < q.size(); k++) begin
         if (gap) begin
            drive(1'b0, 8'hFF, 1'b1, 1'b1);
            @(negedge clk);
            sample(k);
         end
         drive(1'b1, q[k].d, q[k].sop, q[k].eop);
         @(negedge clk);
         sample(k);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) begin
         @(negedge clk);
         sample(-2);
      end
      q.delete();
   endtask

   task automatic check_fields(input string tag, input logic [7:0] et, input logic [15:0] qty);
      check({tag, ".exec"},  ExecType_o, et);
      check({tag, ".ud0"},   ud0, 8'h10);
      check({tag, ".ud3"},   ud3, 8'h13);
      check({tag, ".ud7"},   ud7, 8'h17);
      check({tag, ".stype"}, symbol_type_o, 8'h02);
      check({tag, ".sym"},   sym_o, SYM_AAPL);
      check({tag, ".price"}, price_o, 32'h0001_86A0);
      check({tag, ".qty"},   qty_o, qty);
      check({tag, ".side"},  side_o, 8'h31);
      check({tag, ".ord"},   OrdType_o, 8'h32);
      check({tag, ".tif"},   TimeInForce_o, 8'h30);
   endtask

   task automatic check_counts(input string tag, input int efv, input int efv_at,
                               input int ele, input int ele_at);
      check({tag, ".fv_n"},  fv_n,  efv);
      check({tag, ".fv_at"}, fv_at, efv_at);
      check({tag, ".le_n"},  le_n,  ele);
      check({tag, ".le_at"}, le_at, ele_at);
   endtask

   initial begin
      msgA[0] = 8'h46;
      for (int i = 1; i <= 8; i++) msgA[i] = 8'(8'h0F + i);
      msgA[9]  = 8'h02;
      msgA[10] = 8'h41; msgA[11] = 8'h41; msgA[12] = 8'h50; msgA[13] = 8'h4C;
      for (int i = 14; i <= 29; i++) msgA[i] = 8'h20;
      msgA[30] = 8'h00; msgA[31] = 8'h01; msgA[32] = 8'h86; msgA[33] = 8'hA0;
      msgA[34] = 8'h01; msgA[35] = 8'hF4;
      msgA[36] = 8'h31; msgA[37] = 8'h32; msgA[38] = 8'h30;
      for (int i = 0; i < 39; i++) msgB[i] = msgA[i];
      msgB[0] = 8'h38; msgB[34] = 8'h00; msgB[35] = 8'h64;

      resetn = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("rst.fv",    fields_valid, 1'b0);
      check("rst.le",    len_err, 1'b0);
      check("rst.ready", bus.s_ready, 1'b1);
      check("rst.exec",  ExecType_o, 8'h00);
      check("rst.sym",   sym_o, 160'd0);
      check("rst.price", price_o, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      add_msg(0, 38, 1); send(0);
      check_counts("valid", 1, 38, 0, -1);
      check_fields("valid", 8'h46, 16'd500);

      add_msg(1, 38, 1); send(0);
      check_counts("msgB", 1, 38, 0, -1);
      check_fields("msgB", 8'h38, 16'h0064);

      add_msg(0, 38, 1); send(1);
      check_counts("gap", 1, 38, 0, -1);
      check_fields("gap", 8'h46, 16'd500);

      add_msg(1, 20, 1); add_msg(0, 38, 1); send(0);
      check_counts("short", 1, 59, 1, 20);
      check_fields("short", 8'h46, 16'd500);

      add_msg(0, 38, 0);
      for (int i = 39; i <= 44; i++) q.push_back('{8'hEE, 1'b0, i == 44});
      add_msg(1, 38, 1); send(0);
      check_counts("long", 1, 83, 1, 38);
      check_fields("long", 8'h38, 16'h0064);

      add_msg(0, 14, 0); add_msg(1, 38, 1); send(0);
      check_counts("resop", 1, 53, 1, 15);
      check_fields("resop", 8'h38, 16'h0064);

      q.push_back('{8'h46, 1'b1, 1'b1}); add_msg(0, 38, 1); send(0);
      check_counts("single", 1, 39, 1, 0);
      check_fields("single", 8'h46, 16'd500);

      add_msg(1, 38, 1); add_msg(0, 38, 1); send(0);
      check_counts("b2b", 2, 77, 0, -1);
      check_fields("b2b", 8'h46, 16'd500);

      add_msg(1, 24, 0); send(0);
      check_counts("partial", 0, -1, 0, -1);
      resetn = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("midrst.fv",    fields_valid, 1'b0);
         check("midrst.le",    len_err, 1'b0);
         check("midrst.exec",  ExecType_o, 8'h00);
         check("midrst.sym",   sym_o, 160'd0);
         check("midrst.qty",   qty_o, 16'd0);
         check("midrst.ready", bus.s_ready, 1'b1);
      end
      resetn = 1'b1;
      add_msg(0, 38, 1); send(0);
      check_counts("postrst", 1, 38, 0, -1);
      check_fields("postrst", 8'h46, 16'd500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
